// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encodings, opcode constants and DR select type
package tap_pkg;

    // Standard IEEE 1149.1 4-bit state encodings
    typedef enum logic [3:0] {
        ST_EX2_DR = 4'h0,
        ST_EX1_DR = 4'h1,
        ST_SH_DR  = 4'h2,
        ST_PAU_DR = 4'h3,
        ST_SEL_IR = 4'h4,
        ST_UPD_DR = 4'h5,
        ST_CAP_DR = 4'h6,
        ST_SEL_DR = 4'h7,
        ST_EX2_IR = 4'h8,
        ST_EX1_IR = 4'h9,
        ST_SH_IR  = 4'hA,
        ST_PAU_IR = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPD_IR = 4'hD,
        ST_CAP_IR = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_t;

    // Sliced down to the IR width at the point of use
    localparam logic [31:0] OPC_BYPASS = 32'hFFFF_FFFF;
    localparam logic [31:0] OPC_IDCODE = 32'h0000_0001;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_EXTERNAL
    } dr_sel_t;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// rtl/jtag_tap_controller_if.sv - JTAG pin and external data register bundle
interface jtag_tap_controller_if #(
    parameter int IR_WIDTH = 5
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic [3:0]          tap_state;
    logic [IR_WIDTH-1:0] ir_value;
    logic                dr_capture;
    logic                dr_shift;
    logic                dr_update;
    logic                ext_tdo;

    modport master (
        output tms, tdi, ext_tdo,
        input  tdo, tdo_en, tap_state, ir_value, dr_capture, dr_shift, dr_update
    );

    modport slave (
        input  tms, tdi, ext_tdo,
        output tdo, tdo_en, tap_state, ir_value, dr_capture, dr_shift, dr_update
    );
endinterface

// File: rtl/jtag_shift_reg.sv
// rtl/jtag_shift_reg.sv - capture/shift register, right shift with serial in at MSB
module jtag_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             shift,
    input  logic [WIDTH-1:0] pdata_in,
    input  logic             sin,
    output logic [WIDTH-1:0] pdata_out,
    output logic             sout
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (capture) begin
            q <= pdata_in;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

    assign pdata_out = q;
    assign sout      = q[0];
endmodule

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP with IR, BYPASS, IDCODE and external DR hooks
module jtag_tap_controller
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    jtag_tap_controller_if.slave  bus
);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = OPC_BYPASS[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t          state;
    tap_state_t          state_nxt;
    dr_sel_t             sel;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_value;
    logic                ir_sout;
    logic [31:0]         idcode_q;
    logic                idcode_sout;
    logic                bypass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_TLR:    state_nxt = bus.tms ? ST_TLR    : ST_RTI;
            ST_RTI:    state_nxt = bus.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_nxt = bus.tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_nxt = bus.tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_nxt = bus.tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_nxt = bus.tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_nxt = bus.tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_nxt = bus.tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_nxt = bus.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_nxt = bus.tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_nxt = bus.tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_nxt = bus.tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_nxt = bus.tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_nxt = bus.tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_nxt = bus.tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_nxt = bus.tms ? ST_SEL_DR : ST_RTI;
            default:   state_nxt = ST_TLR;
        endcase
    end

    always_comb begin
        sel = SEL_EXTERNAL;
        if (ir_value == IR_BYPASS) begin
            sel = SEL_BYPASS;
        end else if (ir_value == IR_IDCODE) begin
            sel = SEL_IDCODE;
        end
    end

    jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
        .clk       (clk),
        .rst       (rst),
        .capture   (state == ST_CAP_IR),
        .shift     (state == ST_SH_IR),
        .pdata_in  (IR_CAPTURE),
        .sin       (bus.tdi),
        .pdata_out (ir_q),
        .sout      (ir_sout)
    );

    jtag_shift_reg #(.WIDTH(32)) u_idcode (
        .clk       (clk),
        .rst       (rst),
        .capture   (state == ST_CAP_DR && sel == SEL_IDCODE),
        .shift     (state == ST_SH_DR  && sel == SEL_IDCODE),
        .pdata_in  (IDCODE_VALUE),
        .sin       (bus.tdi),
        .pdata_out (idcode_q),
        .sout      (idcode_sout)
    );

    // Entering TLR wins over everything; Update-IR can never lead straight to TLR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_value <= IR_IDCODE;
        end else if (state_nxt == ST_TLR) begin
            ir_value <= IR_IDCODE;
        end else if (state == ST_UPD_IR) begin
            ir_value <= ir_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else if (sel == SEL_BYPASS) begin
            if (state == ST_CAP_DR) begin
                bypass_q <= 1'b0;
            end else if (state == ST_SH_DR) begin
                bypass_q <= bus.tdi;
            end
        end
    end

    always_comb begin
        bus.tdo = 1'b0;
        if (!rst) begin
            if (state == ST_SH_IR) begin
                bus.tdo = ir_sout;
            end else if (state == ST_SH_DR) begin
                case (sel)
                    SEL_BYPASS: bus.tdo = bypass_q;
                    SEL_IDCODE: bus.tdo = idcode_sout;
                    default:    bus.tdo = bus.ext_tdo;
                endcase
            end
        end
    end

    assign bus.tdo_en     = !rst && (state == ST_SH_IR || state == ST_SH_DR);
    assign bus.dr_capture = !rst && sel == SEL_EXTERNAL && state == ST_CAP_DR;
    assign bus.dr_shift   = !rst && sel == SEL_EXTERNAL && state == ST_SH_DR;
    assign bus.dr_update  = !rst && sel == SEL_EXTERNAL && state == ST_UPD_DR;
    assign bus.tap_state  = state;
    assign bus.ir_value   = ir_value;
endmodule
